// File: rtl/checkout_ctrl.sv
// Checkout controller: latch a commodity selection, price it, collect coins, then vend or refund.
// Optional: define CHECKOUT_CHANGE_RETURN_EN to return overpayment as change during VEND.
module checkout_ctrl #(
  parameter int unsigned N  = 6,
  parameter logic [4:0]  P0 = 5'd2,
  parameter logic [4:0]  P1 = 5'd8,
  parameter logic [4:0]  P2 = 5'd3,
  parameter logic [4:0]  P3 = 5'd10,
  parameter logic [4:0]  P4 = 5'd4,
  parameter logic [4:0]  P5 = 5'd5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sel_valid,
  input  logic [N-1:0] sel_mask,
  output logic         sel_ready,
  input  logic         coin_valid,
  input  logic [4:0]   coin_val,
  output logic         coin_ready,
  input  logic         cancel,
  output logic [7:0]   total,
  output logic [7:0]   paid,
  output logic         vend_valid,
  output logic [N-1:0] vend_mask,
  output logic         change_valid,
  output logic [7:0]   change
);

  typedef enum logic [2:0] {StIdle, StPrice, StPay, StVend, StRefund} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] mask_q, mask_d;
  logic [7:0]   total_q, total_d;
  logic [7:0]   paid_q, paid_d;
  logic [7:0]   price_sum;
  logic [8:0]   paid_sum;

  // Slots beyond the six priced ones cost nothing.
  function automatic logic [7:0] price(input int unsigned j);
    case (j)
      0:       return {3'b000, P0};
      1:       return {3'b000, P1};
      2:       return {3'b000, P2};
      3:       return {3'b000, P3};
      4:       return {3'b000, P4};
      5:       return {3'b000, P5};
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    price_sum = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (mask_q[j]) price_sum = price_sum + price(j);
    end
  end

  assign paid_sum = {1'b0, paid_q} + {4'b0000, coin_val};

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    total_d = total_q;
    paid_d  = paid_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid && (|sel_mask)) begin
          mask_d  = sel_mask;
          state_d = StPrice;
        end
      end
      StPrice: begin
        total_d = price_sum;
        state_d = StPay;
      end
      StPay: begin
        // Cancel wins over a coin offered in the same cycle.
        if (cancel) begin
          if (paid_q != 8'd0) begin
            state_d = StRefund;
          end else begin
            state_d = StIdle;
            mask_d  = '0;
            total_d = '0;
          end
        end else if (coin_valid) begin
          paid_d = paid_sum[8] ? 8'hff : paid_sum[7:0];
          if (paid_d >= total_q) state_d = StVend;
        end
      end
      StVend, StRefund: begin
        state_d = StIdle;
        mask_d  = '0;
        total_d = '0;
        paid_d  = '0;
      end
      default: begin
        state_d = StIdle;
        mask_d  = '0;
        total_d = '0;
        paid_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      total_q <= '0;
      paid_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      total_q <= total_d;
      paid_q  <= paid_d;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    sel_ready    = (state_q == StIdle);
    coin_ready   = (state_q == StPay);
    vend_valid   = (state_q == StVend);
    vend_mask    = (state_q == StVend) ? mask_q : '0;
    total        = total_q;
    paid         = paid_q;
    change_valid = 1'b0;
    change       = 8'd0;
    if (state_q == StRefund) begin
      change_valid = 1'b1;
      change       = paid_q;
    end
`ifdef CHECKOUT_CHANGE_RETURN_EN
    if ((state_q == StVend) && (paid_q > total_q)) begin
      change_valid = 1'b1;
      change       = paid_q - total_q;
    end
`endif
  end

endmodule

// File: tb/tb_checkout_ctrl.sv
// Directed self-checking bench for checkout_ctrl with hand-computed expectations.
module tb_checkout_ctrl;

  logic       clk, rst_n;
  logic       sel_valid, sel_ready;
  logic [5:0] sel_mask;
  logic       coin_valid, coin_ready;
  logic [4:0] coin_val;
  logic       cancel;
  logic [7:0] total, paid;
  logic       vend_valid, change_valid;
  logic [5:0] vend_mask;
  logic [7:0] change;

  int n_checks = 0;
  int n_pass   = 0;

  checkout_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel_valid    (sel_valid),
    .sel_mask     (sel_mask),
    .sel_ready    (sel_ready),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .coin_ready   (coin_ready),
    .cancel       (cancel),
    .total        (total),
    .paid         (paid),
    .vend_valid   (vend_valid),
    .vend_mask    (vend_mask),
    .change_valid (change_valid),
    .change       (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sel_valid  = 1'b0;
    sel_mask   = '0;
    coin_valid = 1'b0;
    coin_val   = '0;
    cancel     = 1'b0;
  endtask

  // Offer a selection in IDLE, then wait through PRICE into PAY.
  task automatic select(input logic [5:0] m);
    sel_valid = 1'b1;
    sel_mask  = m;
    step();
    idle_inputs();
    step();
  endtask

  task automatic coin(input logic [4:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_sel_ready", sel_ready, 1);
    check("rst_coin_ready", coin_ready, 0);
    check("rst_total", total, 0);
    check("rst_pulses", {vend_valid, change_valid}, 0);
    rst_n = 1'b1;
    step();

    // Two slots 0,1: 2+8=10, paid exactly.
    sel_valid = 1'b1;
    sel_mask  = 6'b000011;
    step();
    idle_inputs();
    check("s1_price_sel_ready", sel_ready, 0);
    step();
    check("s1_total", total, 10);
    check("s1_coin_ready", coin_ready, 1);
    coin(5'd5);
    check("s1_paid5", paid, 5);
    check("s1_no_vend_yet", vend_valid, 0);
    coin(5'd5);
    check("s1_vend_valid", vend_valid, 1);
    check("s1_vend_mask", vend_mask, 6'b000011);
    check("s1_no_change", change_valid, 0);
    step();
    check("s1_vend_pulse_end", vend_valid, 0);
    check("s1_paid_clr", paid, 0);
    check("s1_total_clr", total, 0);
    check("s1_idle", sel_ready, 1);

    // All slots: 32, overpay to 62.
    select(6'b111111);
    check("s2_total", total, 32);
    coin(5'd31);
    check("s2_paid31", paid, 31);
    coin(5'd31);
    check("s2_vend_valid", vend_valid, 1);
    check("s2_vend_mask", vend_mask, 6'b111111);
`ifdef CHECKOUT_CHANGE_RETURN_EN
    check("s2_change_valid", change_valid, 1);
    check("s2_change", change, 30);
`else
    check("s2_change_valid", change_valid, 0);
    check("s2_change", change, 0);
`endif
    step();

    // Slot 2: 3, pay 2 then cancel.
    select(6'b000100);
    check("s3_total", total, 3);
    coin(5'd2);
    check("s3_paid", paid, 2);
    cancel = 1'b1;
    step();
    idle_inputs();
    check("s3_change_valid", change_valid, 1);
    check("s3_change", change, 2);
    check("s3_no_vend", vend_valid, 0);
    step();
    check("s3_idle", sel_ready, 1);
    check("s3_change_end", change_valid, 0);

    // Slot 1: 8, pay 4, cancel with simultaneous coin 9.
    select(6'b000010);
    coin(5'd4);
    check("s4_paid", paid, 4);
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_val   = 5'd9;
    step();
    idle_inputs();
    check("s4_change_valid", change_valid, 1);
    check("s4_change", change, 4);
    step();

    // Empty selection ignored; coin ignored in IDLE.
    sel_valid = 1'b1;
    sel_mask  = 6'b000000;
    step();
    idle_inputs();
    check("s5_stay_idle", sel_ready, 1);
    check("s5_total0", total, 0);
    coin(5'd7);
    check("s5_coin_ignored", paid, 0);
    // Cancel in PAY with nothing paid.
    select(6'b000001);
    check("s5_total2", total, 2);
    cancel = 1'b1;
    step();
    idle_inputs();
    check("s5_cancel_idle", sel_ready, 1);
    check("s5_cancel_pulses", {vend_valid, change_valid}, 0);
    check("s5_cancel_total", total, 0);

    // Reset in PAY with paid=7.
    select(6'b001000);
    check("s6_total", total, 10);
    coin(5'd7);
    check("s6_paid", paid, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_idle", sel_ready, 1);
    check("s6_rst_paid", paid, 0);
    check("s6_rst_total", total, 0);
    check("s6_rst_coin_ready", coin_ready, 0);
    rst_n = 1'b1;
    step();
    check("s6_no_pulses", {vend_valid, change_valid}, 0);
    check("s6_still_idle", sel_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/checkout_ctrl.md
CHECKOUT_CTRL -- requirements
Module: checkout_ctrl

Interface
REQ-001 SHALL have parameter N, default 6: number of commodity slots.
REQ-002 SHALL have parameters P0..P5, 5-bit each, defaults 2, 8, 3, 10, 4, 5: unit price of slots 0..5.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sel_valid  input  1  the selection on sel_mask is offered.
REQ-006 SHALL have port sel_mask  input  N  selected commodities, one bit per slot.
REQ-007 SHALL have port sel_ready  output  1  the block can accept a selection.
REQ-008 SHALL have port coin_valid  input  1  a coin is offered.
REQ-009 SHALL have port coin_val  input  5  value of the offered coin.
REQ-010 SHALL have port coin_ready  output  1  the block can accept a coin.
REQ-011 SHALL have port cancel  input  1  abort the current transaction.
REQ-012 SHALL have port total  output  8  registered price sum of the latched selection.
REQ-013 SHALL have port paid  output  8  registered accumulated payment.
REQ-014 SHALL have port vend_valid  output  1  one-cycle pulse: dispense vend_mask.
REQ-015 SHALL have port vend_mask  output  N  latched selection, valid while vend_valid=1.
REQ-016 SHALL have port change_valid  output  1  one-cycle pulse: return change.
REQ-017 SHALL have port change  output  8  amount to return, valid while change_valid=1, else 0.

Function
REQ-018 SHALL implement states IDLE, PRICE, PAY, VEND, REFUND.
REQ-019 IDLE: sel_ready=1; other handshake outputs 0.
REQ-020 IDLE: when sel_valid=1 and sel_mask!=0, latch sel_mask and go to PRICE.
REQ-021 IDLE: when sel_valid=1 and sel_mask==0, ignore the offer and stay in IDLE.
REQ-022 PRICE: load total with the sum of Pj over the set bits of the latched mask, computed at 8-bit width with no overflow; go to PAY; total is valid 2 cycles after acceptance.
REQ-023 PAY: coin_ready=1; a coin is accepted when coin_valid=1 and no cancel.
REQ-024 PAY: an accepted coin sets paid to paid+coin_val, saturating at 255.
REQ-025 PAY: if the updated paid is >= total, go to VEND; otherwise stay in PAY.
REQ-026 PAY: cancel=1 has priority over a coin in the same cycle; that coin is not accepted.
REQ-027 PAY: on cancel, go to REFUND if paid>0, else go to IDLE.
REQ-028 VEND: for one cycle, vend_valid=1 and vend_mask=latched mask; then go to IDLE and clear paid, total and the latched mask.
REQ-029 REFUND: for one cycle, change_valid=1 and change=paid; then go to IDLE and clear paid, total and the latched mask.
REQ-030 cancel SHALL be ignored in IDLE, PRICE, VEND and REFUND.
REQ-031 coin_valid SHALL be ignored outside PAY, and coin_val SHALL have no effect there.
REQ-032 sel_valid SHALL be ignored outside IDLE.
REQ-033 All outputs SHALL be registered or decoded from the state register only; no input-to-output combinational path.

Reset
REQ-034 On rst_n=0, state SHALL go to IDLE immediately (asynchronously).
REQ-035 On rst_n=0, total, paid, change and vend_mask SHALL be 0, and vend_valid, change_valid and coin_ready SHALL be 0; sel_ready SHALL be 1 after reset.
REQ-036 Reset mid-transaction SHALL discard the latched selection and payment, with no vend or change pulse.

Configuration
REQ-037 With macro CHECKOUT_CHANGE_RETURN_EN defined, VEND SHALL also assert change_valid=1 with change=paid-total when paid>total.
REQ-038 Without the macro, VEND SHALL keep change_valid=0 and change=0; any overpayment is retained; REFUND behaviour is unchanged.

Verification
REQ-039 Bench SHALL cover: sel_mask=000011 accepted -> total=10 two cycles later; coins 5, 5 -> vend_valid pulse, vend_mask=000011, no change.
REQ-040 Bench SHALL cover: sel_mask=111111 -> total=32; coins 31, 31 -> vend; with macro change_valid=1 and change=30; without macro change_valid=0.
REQ-041 Bench SHALL cover: sel_mask=000100 -> total=3; coin 2; cancel -> change_valid=1, change=2, then IDLE with sel_ready=1.
REQ-042 Bench SHALL cover: in PAY with paid=4, cancel and coin_valid (value 9) in the same cycle -> refund change=4, coin not accepted.
REQ-043 Bench SHALL cover: sel_valid with sel_mask=0 -> stays IDLE, total=0; and cancel in PAY with paid=0 -> IDLE with no pulse.
REQ-044 Bench SHALL cover: rst_n low in PAY with paid=7 -> state IDLE, paid=0, total=0, no pulses.
